id_ex_alu_issue: RTL

ID_EX_ALU_ISSUE -- requirements
Module: id_ex_alu_issue

---
 rtl/id_ex_alu_issue_pkg.sv | 79 +++++++
 rtl/id_ex_alu_issue_if.sv | 59 +++++
 rtl/id_ex_alu_issue_alu_op_decoder.sv | 105 ++++++++++
 rtl/id_ex_alu_issue.sv | 102 ++++++++++
 4 files changed

// File: rtl/id_ex_alu_issue_pkg.sv
// ============================================================================
// Module   : id_ex_alu_issue_pkg
// Brief    : Opcodes, funct3 codes, ALU-op encodings and forwarding helper
//            shared by the ID/EX issue stage and the ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_ex_alu_issue_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] C_OP_STORE  = 7'b0100011;
   localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] C_OP_JAL    = 7'b1101111;

   localparam logic [2:0] C_F3_ADD  = 3'b000;
   localparam logic [2:0] C_F3_SLL  = 3'b001;
   localparam logic [2:0] C_F3_SLT  = 3'b010;
   localparam logic [2:0] C_F3_SLTU = 3'b011;
   localparam logic [2:0] C_F3_XOR  = 3'b100;
   localparam logic [2:0] C_F3_SR   = 3'b101;
   localparam logic [2:0] C_F3_OR   = 3'b110;
   localparam logic [2:0] C_F3_AND  = 3'b111;

   localparam logic [2:0] C_F3_BEQ  = 3'b000;
   localparam logic [2:0] C_F3_BNE  = 3'b001;
   localparam logic [2:0] C_F3_BLT  = 3'b100;
   localparam logic [2:0] C_F3_BGE  = 3'b101;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_op_e;

   // brinv flips the sense of zero_e: bne/blt take the branch on a non-zero result
   typedef struct packed {
      logic       valid;
      logic       illegal;
      logic       regwrite;
      logic       memwrite;
      logic       alusrc;
      logic       branch;
      logic       jump;
      logic       brinv;
      logic [2:0] alucontrol;
   } ex_ctrl_t;

   function automatic logic [XLEN-1:0] fwd_operand(
      input logic [4:0]      rs,
      input logic [XLEN-1:0] regval,
      input logic [4:0]      rd_m,
      input logic            regwrite_m,
      input logic [XLEN-1:0] aluresult_m,
      input logic [4:0]      rd_w,
      input logic            regwrite_w,
      input logic [XLEN-1:0] result_w
   );
      if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         return aluresult_m;
      end
      if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         return result_w;
      end
      return regval;
   endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_alu_issue_if.sv
// ============================================================================
// Module   : id_ex_alu_issue_if
// Brief    : Decode-side, hazard, forwarding and EX-side signals of the issue stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_alu_issue_if;
   import id_ex_alu_issue_pkg::*;

   logic            valid_d;
   logic [6:0]      op_d;
   logic [2:0]      funct3_d;
   logic            funct7b5_d;
   logic [4:0]      rs1_d;
   logic [4:0]      rs2_d;
   logic [4:0]      rd_d;
   logic [XLEN-1:0] rd1_d;
   logic [XLEN-1:0] rd2_d;
   logic [XLEN-1:0] immext_d;
   logic            stall_e;
   logic            flush_e;
   logic [XLEN-1:0] aluresult_m;
   logic [4:0]      rd_m;
   logic            regwrite_m;
   logic [XLEN-1:0] result_w;
   logic [4:0]      rd_w;
   logic            regwrite_w;
   logic            zero_e;
   logic [XLEN-1:0] srca_e;
   logic [XLEN-1:0] srcb_e;
   logic [2:0]      alucontrol_e;
   logic [XLEN-1:0] writedata_e;
   logic [4:0]      rd_e;
   logic            regwrite_e;
   logic            memwrite_e;
   logic            valid_e;
   logic            illegal_e;
   logic            pcsrc_e;

   modport master (
      output valid_d, op_d, funct3_d, funct7b5_d, rs1_d, rs2_d, rd_d,
             rd1_d, rd2_d, immext_d, stall_e, flush_e,
             aluresult_m, rd_m, regwrite_m, result_w, rd_w, regwrite_w, zero_e,
      input  srca_e, srcb_e, alucontrol_e, writedata_e, rd_e,
             regwrite_e, memwrite_e, valid_e, illegal_e, pcsrc_e
   );

   modport slave (
      input  valid_d, op_d, funct3_d, funct7b5_d, rs1_d, rs2_d, rd_d,
             rd1_d, rd2_d, immext_d, stall_e, flush_e,
             aluresult_m, rd_m, regwrite_m, result_w, rd_w, regwrite_w, zero_e,
      output srca_e, srcb_e, alucontrol_e, writedata_e, rd_e,
             regwrite_e, memwrite_e, valid_e, illegal_e, pcsrc_e
   );

endinterface

`default_nettype wire

// File: rtl/id_ex_alu_issue_alu_op_decoder.sv
// ============================================================================
// Module   : alu_op_decoder
// Brief    : Combinational opcode/funct decode into ALU op and stage controls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_decoder
   import id_ex_alu_issue_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [2:0] alucontrol,
   output logic       alusrc,
   output logic       regwrite,
   output logic       memwrite,
   output logic       branch,
   output logic       jump,
   output logic       illegal
);

   alu_op_e w_alu;
   logic    w_alusrc;
   logic    w_regwrite;
   logic    w_memwrite;
   logic    w_branch;
   logic    w_jump;
   logic    w_illegal;

   always_comb begin
      w_alu      = ALU_ADD;
      w_alusrc   = 1'b0;
      w_regwrite = 1'b0;
      w_memwrite = 1'b0;
      w_branch   = 1'b0;
      w_jump     = 1'b0;
      w_illegal  = 1'b0;
      case (op)
         C_OP_RTYPE, C_OP_ITYPE: begin
            w_alusrc   = (op == C_OP_ITYPE);
            w_regwrite = 1'b1;
            case (funct3)
               // funct7b5 selects sub only for register-register adds
               C_F3_ADD: w_alu = (op == C_OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
               C_F3_AND: w_alu = ALU_AND;
               C_F3_OR:  w_alu = ALU_OR;
               C_F3_XOR: w_alu = ALU_XOR;
               C_F3_SLT: w_alu = ALU_SLT;
               C_F3_SLL: w_alu = ALU_SLL;
               C_F3_SR: begin
                  if (funct7b5) begin
                     w_illegal = 1'b1;
                  end else begin
                     w_alu = ALU_SRL;
                  end
               end
               default: w_illegal = 1'b1;
            endcase
         end
         C_OP_LOAD: begin
            w_alusrc   = 1'b1;
            w_regwrite = 1'b1;
         end
         C_OP_STORE: begin
            w_alusrc   = 1'b1;
            w_memwrite = 1'b1;
         end
         C_OP_BRANCH: begin
            w_branch = 1'b1;
            case (funct3)
               C_F3_BEQ, C_F3_BNE: w_alu = ALU_SUB;
               C_F3_BLT, C_F3_BGE: w_alu = ALU_SLT;
               default:            w_illegal = 1'b1;
            endcase
         end
         C_OP_JAL: begin
            w_alusrc   = 1'b1;
            w_regwrite = 1'b1;
            w_jump     = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase

      if (w_illegal) begin
         w_alu      = ALU_ADD;
         w_alusrc   = 1'b0;
         w_regwrite = 1'b0;
         w_memwrite = 1'b0;
         w_branch   = 1'b0;
         w_jump     = 1'b0;
      end
   end

   assign alucontrol = w_alu;
   assign alusrc     = w_alusrc;
   assign regwrite   = w_regwrite;
   assign memwrite   = w_memwrite;
   assign branch     = w_branch;
   assign jump       = w_jump;
   assign illegal    = w_illegal;

endmodule

`default_nettype wire

// File: rtl/id_ex_alu_issue.sv
// ============================================================================
// Module   : id_ex_alu_issue
// Brief    : ID/EX pipeline register with operand forwarding and redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_alu_issue
   import id_ex_alu_issue_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   id_ex_alu_issue_if.slave  bus
);

   logic [2:0]      w_alucontrol;
   logic            w_alusrc;
   logic            w_regwrite;
   logic            w_memwrite;
   logic            w_branch;
   logic            w_jump;
   logic            w_illegal;
   ex_ctrl_t        w_ctrl_d;

   ex_ctrl_t        r_ctrl;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_rd1;
   logic [XLEN-1:0] r_rd2;
   logic [XLEN-1:0] r_imm;

   logic [XLEN-1:0] w_fwd_a;
   logic [XLEN-1:0] w_fwd_b;

   alu_op_decoder u_dec (
      .op         (bus.op_d),
      .funct3     (bus.funct3_d),
      .funct7b5   (bus.funct7b5_d),
      .alucontrol (w_alucontrol),
      .alusrc     (w_alusrc),
      .regwrite   (w_regwrite),
      .memwrite   (w_memwrite),
      .branch     (w_branch),
      .jump       (w_jump),
      .illegal    (w_illegal)
   );

   always_comb begin
      w_ctrl_d            = '0;
      w_ctrl_d.valid      = 1'b1;
      w_ctrl_d.illegal    = w_illegal;
      w_ctrl_d.regwrite   = w_regwrite;
      w_ctrl_d.memwrite   = w_memwrite;
      w_ctrl_d.alusrc     = w_alusrc;
      w_ctrl_d.branch     = w_branch;
      w_ctrl_d.jump       = w_jump;
      w_ctrl_d.brinv      = bus.funct3_d[0] ^ bus.funct3_d[2];
      w_ctrl_d.alucontrol = w_alucontrol;
   end

   // Reset beats flush beats stall; an empty decode slot also loads a bubble
   always_ff @(posedge clk) begin
      if (!reset || bus.flush_e || (!bus.stall_e && !bus.valid_d)) begin
         r_ctrl <= '0;
         r_rs1  <= '0;
         r_rs2  <= '0;
         r_rd   <= '0;
         r_rd1  <= '0;
         r_rd2  <= '0;
         r_imm  <= '0;
      end else if (!bus.stall_e) begin
         r_ctrl <= w_ctrl_d;
         r_rs1  <= bus.rs1_d;
         r_rs2  <= bus.rs2_d;
         r_rd   <= bus.rd_d;
         r_rd1  <= bus.rd1_d;
         r_rd2  <= bus.rd2_d;
         r_imm  <= bus.immext_d;
      end
   end

   assign w_fwd_a = fwd_operand(r_rs1, r_rd1, bus.rd_m, bus.regwrite_m, bus.aluresult_m,
                                bus.rd_w, bus.regwrite_w, bus.result_w);
   assign w_fwd_b = fwd_operand(r_rs2, r_rd2, bus.rd_m, bus.regwrite_m, bus.aluresult_m,
                                bus.rd_w, bus.regwrite_w, bus.result_w);

   assign bus.srca_e       = w_fwd_a;
   assign bus.srcb_e       = r_ctrl.alusrc ? r_imm : w_fwd_b;
   assign bus.writedata_e  = w_fwd_b;
   assign bus.alucontrol_e = r_ctrl.alucontrol;
   assign bus.rd_e         = r_rd;
   assign bus.valid_e      = r_ctrl.valid;
   assign bus.illegal_e    = r_ctrl.illegal;
   assign bus.regwrite_e   = r_ctrl.valid & r_ctrl.regwrite;
   assign bus.memwrite_e   = r_ctrl.valid & r_ctrl.memwrite;
   assign bus.pcsrc_e      = r_ctrl.valid &
                             (r_ctrl.jump | (r_ctrl.branch & (bus.zero_e ^ r_ctrl.brinv)));

endmodule

`default_nettype wire
